// File: rtl/estado_jogadores_pkg.sv
// Shared definitions for the werewolf game datapath and its controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: role codes, player-count defaults, controller state encoding
// (the latter is used for debug decode of the controller's state bus).
package pkg_lobinho;

  localparam int N_JOGADORES_DEF = 5;
  localparam int W_J_DEF         = 3;

  localparam logic [1:0] CLASSE_ALDEAO = 2'd0;
  localparam logic [1:0] CLASSE_LOBO   = 2'd1;
  localparam logic [1:0] CLASSE_ANJO   = 2'd2;

  typedef enum logic [3:0] {
    ST_INICIAL       = 4'd0,
    ST_GERA_SEED     = 4'd1,
    ST_NOITE_INICIO  = 4'd2,
    ST_NOITE_ACAO    = 4'd3,
    ST_NOITE_PROXIMO = 4'd4,
    ST_AVALIA_NOITE  = 4'd5,
    ST_CHECAR_NOITE  = 4'd6,
    ST_DIA_VOTO      = 4'd7,
    ST_PROCESSA_VOTO = 4'd8,
    ST_CHECAR_DIA    = 4'd9,
    ST_FIM_JOGO      = 4'd10
  } estado_ctrl_t;

endpackage

// File: rtl/estado_jogadores_contador.sv
// Small up-counter with synchronous clear, enable and wrap/saturate mode.
// Latency: count visible one cycle after the enable/clear cycle.
// Backpressure: none; clear beats enable, saturating mode holds at MAX.
// Ports: clock, reset (async, active-high), i_clr, i_en, i_wrap
// (1 = wrap MAX -> 0, 0 = saturate at MAX), o_cnt.
module contador_mod #(
  parameter int           W   = 3,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic         i_wrap,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (r_cnt == MAX) begin
        if (i_wrap) r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/estado_jogadores.sv
// Werewolf game datapath: roles, alive mask, night targets and day vote.
// Latency: all state updates one cycle after the strobe; flags are combinational.
// Backpressure: none; strobes are executed the cycle they are seen.
// Ports: controller strobes in (rst_global, zera_CJ, inc_jogador, inc_seed,
// e_seed_reg, processar_acao, avaliar_eliminacao, voto, morra, confirma, alvo);
// status flags out (CJ_fim, jogador_vivo, acertou, votou, sinal_lobo_ganhou)
// plus jogador_atual, classe_atual, vivos, vitima_noite, vitima_valida.
module estado_jogadores
  import pkg_lobinho::*;
#(
  parameter int N_JOGADORES = N_JOGADORES_DEF,
  parameter int W_J         = W_J_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rst_global,
  input  logic                   zera_CJ,
  input  logic                   inc_jogador,
  input  logic                   inc_seed,
  input  logic                   e_seed_reg,
  input  logic                   processar_acao,
  input  logic                   avaliar_eliminacao,
  input  logic                   voto,
  input  logic                   morra,
  input  logic                   confirma,
  input  logic [W_J-1:0]         alvo,
  output logic                   CJ_fim,
  output logic                   jogador_vivo,
  output logic                   acertou,
  output logic                   votou,
  output logic                   sinal_lobo_ganhou,
  output logic [W_J-1:0]         jogador_atual,
  output logic [1:0]             classe_atual,
  output logic [N_JOGADORES-1:0] vivos,
  output logic [W_J-1:0]         vitima_noite,
  output logic                   vitima_valida
);

  localparam logic [W_J-1:0] ULTIMO = W_J'(N_JOGADORES - 1);

  logic [W_J-1:0]         w_seed;
  logic [W_J-1:0]         w_jogador;
  logic [W_J-1:0]         w_anjo_id;
  logic [1:0]             w_classe;
  logic [2**W_J-1:0]      w_vivos_pad;
  logic                   w_alvo_ok;
  logic                   w_mata_noite;
  logic [N_JOGADORES-1:0] w_kill;
  logic [W_J:0]           w_pop;

  logic [W_J-1:0]         r_lobo_id;
  logic [W_J-1:0]         r_alvo_lobo;
  logic                   r_lobo_vld;
  logic [W_J-1:0]         r_alvo_prot;
  logic                   r_prot_vld;
  logic [W_J-1:0]         r_voto_alvo;
  logic                   r_votou;
  logic [N_JOGADORES-1:0] r_vivos;
  logic [W_J-1:0]         r_vitima_noite;
  logic                   r_vitima_valida;

  contador_mod #(.W(W_J), .MAX(ULTIMO)) u_seed (
    .clock (clock),
    .reset (reset),
    .i_clr (rst_global),
    .i_en  (inc_seed),
    .i_wrap(1'b1),
    .o_cnt (w_seed)
  );

  contador_mod #(.W(W_J), .MAX(ULTIMO)) u_jogador (
    .clock (clock),
    .reset (reset),
    .i_clr (rst_global | zera_CJ),
    .i_en  (inc_jogador),
    .i_wrap(1'b0),
    .o_cnt (w_jogador)
  );

  // Zero-extended alive mask so any switch value can index it safely;
  // indices >= N_JOGADORES read as dead.
  assign w_vivos_pad = (2**W_J)'(r_vivos);
  assign w_alvo_ok   = (alvo < W_J'(N_JOGADORES)) && w_vivos_pad[alvo];

  assign w_anjo_id = (r_lobo_id == ULTIMO) ? '0 : r_lobo_id + 1'b1;

  always_comb begin
    w_classe = CLASSE_ALDEAO;
    if (w_jogador == r_lobo_id)      w_classe = CLASSE_LOBO;
    else if (w_jogador == w_anjo_id) w_classe = CLASSE_ANJO;
  end

  // The night kill succeeds unless the angel guarded the same player.
  assign w_mata_noite = avaliar_eliminacao && r_lobo_vld &&
                        (!r_prot_vld || (r_alvo_prot != r_alvo_lobo));

  // Night kill and lynch can coincide; both are folded into one clear mask.
  always_comb begin
    w_kill = '0;
    for (int i = 0; i < N_JOGADORES; i++) begin
      if (w_mata_noite && (r_alvo_lobo == W_J'(i))) w_kill[i] = 1'b1;
      if (morra && r_votou && (r_voto_alvo == W_J'(i))) w_kill[i] = 1'b1;
    end
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_JOGADORES; i++) w_pop = w_pop + (W_J+1)'(r_vivos[i]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_lobo_id <= '0;
    end else if (rst_global) begin
      r_lobo_id <= '0;
    end else if (e_seed_reg) begin
      r_lobo_id <= w_seed;
    end
  end

  // Night targets: only the acting wolf/angel may set them, and only on living
  // in-range players. The wolf cannot target itself.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_alvo_lobo <= '0;
      r_lobo_vld  <= 1'b0;
      r_alvo_prot <= '0;
      r_prot_vld  <= 1'b0;
    end else if (rst_global || zera_CJ) begin
      r_lobo_vld  <= 1'b0;
      r_prot_vld  <= 1'b0;
    end else if (processar_acao && confirma && w_alvo_ok) begin
      if ((w_classe == CLASSE_LOBO) && (alvo != r_lobo_id)) begin
        r_alvo_lobo <= alvo;
        r_lobo_vld  <= 1'b1;
      end
      if (w_classe == CLASSE_ANJO) begin
        r_alvo_prot <= alvo;
        r_prot_vld  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_vivos         <= '1;
      r_voto_alvo     <= '0;
      r_votou         <= 1'b0;
      r_vitima_noite  <= '0;
      r_vitima_valida <= 1'b0;
    end else if (rst_global) begin
      r_vivos         <= '1;
      r_voto_alvo     <= '0;
      r_votou         <= 1'b0;
      r_vitima_noite  <= '0;
      r_vitima_valida <= 1'b0;
    end else begin
      r_vivos <= r_vivos & ~w_kill;
      if (avaliar_eliminacao) begin
        // Resolving the night also opens a fresh day vote.
        r_votou <= 1'b0;
        if (w_mata_noite) begin
          r_vitima_noite  <= r_alvo_lobo;
          r_vitima_valida <= 1'b1;
        end else begin
          r_vitima_valida <= 1'b0;
        end
      end else if (voto && confirma && w_alvo_ok && !r_votou) begin
        r_voto_alvo <= alvo;
        r_votou     <= 1'b1;
      end
    end
  end

  assign jogador_atual     = w_jogador;
  assign classe_atual      = w_classe;
  assign CJ_fim            = (w_jogador == ULTIMO);
  assign jogador_vivo      = w_vivos_pad[w_jogador];
  assign votou             = r_votou;
  assign acertou           = r_votou && (r_voto_alvo == r_lobo_id);
  assign sinal_lobo_ganhou = w_vivos_pad[r_lobo_id] && (w_pop <= (W_J+1)'(2));
  assign vivos             = r_vivos;
  assign vitima_noite      = r_vitima_noite;
  assign vitima_valida     = r_vitima_valida;

endmodule

// File: tb/tb_estado_jogadores.sv
// Directed bench for estado_jogadores: table of one-cycle strobe vectors
// with hand-computed expected outputs, plus an async-reset sequence.
module tb_estado_jogadores;

  localparam logic [9:0] S_RST   = 10'd1;
  localparam logic [9:0] S_ZERA  = 10'd2;
  localparam logic [9:0] S_INCJ  = 10'd4;
  localparam logic [9:0] S_INCS  = 10'd8;
  localparam logic [9:0] S_ESEED = 10'd16;
  localparam logic [9:0] S_PROC  = 10'd32;
  localparam logic [9:0] S_AVAL  = 10'd64;
  localparam logic [9:0] S_VOTO  = 10'd128;
  localparam logic [9:0] S_MORRA = 10'd256;
  localparam logic [9:0] S_CONF  = 10'd512;

  logic       clock = 1'b0;
  logic       reset;
  logic       rst_global, zera_CJ, inc_jogador, inc_seed, e_seed_reg;
  logic       processar_acao, avaliar_eliminacao, voto, morra, confirma;
  logic [2:0] alvo;
  logic       CJ_fim, jogador_vivo, acertou, votou, sinal_lobo_ganhou;
  logic [2:0] jogador_atual;
  logic [1:0] classe_atual;
  logic [4:0] vivos;
  logic [2:0] vitima_noite;
  logic       vitima_valida;

  int n_checks = 0;
  int n_fail   = 0;

  // flags = {votou, acertou, CJ_fim, sinal_lobo_ganhou, vitima_valida}
  typedef struct {
    string      nome;
    logic [9:0] s;
    logic [2:0] alvo;
    logic [4:0] viv;
    logic [2:0] jog;
    logic [1:0] cls;
    logic [4:0] flags;
    logic [2:0] vit;
  } vec_t;

  vec_t tab[$];

  estado_jogadores #(.N_JOGADORES(5), .W_J(3)) dut (
    .clock             (clock),
    .reset             (reset),
    .rst_global        (rst_global),
    .zera_CJ           (zera_CJ),
    .inc_jogador       (inc_jogador),
    .inc_seed          (inc_seed),
    .e_seed_reg        (e_seed_reg),
    .processar_acao    (processar_acao),
    .avaliar_eliminacao(avaliar_eliminacao),
    .voto              (voto),
    .morra             (morra),
    .confirma          (confirma),
    .alvo              (alvo),
    .CJ_fim            (CJ_fim),
    .jogador_vivo      (jogador_vivo),
    .acertou           (acertou),
    .votou             (votou),
    .sinal_lobo_ganhou (sinal_lobo_ganhou),
    .jogador_atual     (jogador_atual),
    .classe_atual      (classe_atual),
    .vivos             (vivos),
    .vitima_noite      (vitima_noite),
    .vitima_valida     (vitima_valida)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic [9:0] s, input logic [2:0] a);
    rst_global         = s[0];
    zera_CJ            = s[1];
    inc_jogador        = s[2];
    inc_seed           = s[3];
    e_seed_reg         = s[4];
    processar_acao     = s[5];
    avaliar_eliminacao = s[6];
    voto               = s[7];
    morra              = s[8];
    confirma           = s[9];
    alvo               = a;
  endtask

  task automatic add(input string n, input logic [9:0] s, input logic [2:0] a,
                     input logic [4:0] viv, input logic [2:0] jog, input logic [1:0] cls,
                     input logic [4:0] fl, input logic [2:0] vit);
    vec_t v;
    v.nome = n; v.s = s; v.alvo = a; v.viv = viv; v.jog = jog;
    v.cls = cls; v.flags = fl; v.vit = vit;
    tab.push_back(v);
  endtask

  // Layout: {vivos, jog, classe, votou, acertou, fim, ganhou, vval, vitima, jogador_vivo}
  task automatic check(input string n, input logic [4:0] viv, input logic [2:0] jog,
                       input logic [1:0] cls, input logic [4:0] fl, input logic [2:0] vit);
    logic [18:0] act, exp;
    act = {vivos, jogador_atual, classe_atual, votou, acertou, CJ_fim,
           sinal_lobo_ganhou, vitima_valida, vitima_noite, jogador_vivo};
    exp = {viv, jog, cls, fl, vit, viv[jog]};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h (vivos,jog,cls,flags,vit,jv)", n, act, exp);
    end
  endtask

  task automatic run_tab();
    foreach (tab[k]) begin
      drive(tab[k].s, tab[k].alvo);
      @(posedge clock);
      #1;
      check(tab[k].nome, tab[k].viv, tab[k].jog, tab[k].cls, tab[k].flags, tab[k].vit);
    end
    drive('0, '0);
    tab.delete();
  endtask

  initial begin
    reset = 1'b1;
    drive('0, '0);
    #12;
    check("reset_state", 5'b11111, 3'd0, 2'd1, 5'b00000, 3'd0);
    reset = 1'b0;

    // Seed and roles: lobo=2, anjo=3
    for (int i = 0; i < 7; i++) add("inc_seed", S_INCS, 0, 5'b11111, 0, 1, 5'b00000, 0);
    add("e_seed",       S_ESEED,        0, 5'b11111, 0, 0, 5'b00000, 0);
    add("jog1",         S_INCJ,         0, 5'b11111, 1, 0, 5'b00000, 0);
    add("jog2_lobo",    S_INCJ,         0, 5'b11111, 2, 1, 5'b00000, 0);
    // Night 1: wolf picks 0; later self (2) and out-of-range (6) must be ignored
    add("lobo_alvo0",   S_PROC|S_CONF,  0, 5'b11111, 2, 1, 5'b00000, 0);
    add("lobo_alvo6",   S_PROC|S_CONF,  6, 5'b11111, 2, 1, 5'b00000, 0);
    add("lobo_alvo2",   S_PROC|S_CONF,  2, 5'b11111, 2, 1, 5'b00000, 0);
    add("jog3_anjo",    S_INCJ,         0, 5'b11111, 3, 2, 5'b00000, 0);
    add("anjo_alvo4",   S_PROC|S_CONF,  4, 5'b11111, 3, 2, 5'b00000, 0);
    add("kill0",        S_AVAL,         0, 5'b11110, 3, 2, 5'b00001, 0);
    // Day 1 vote: dead target rejected, first accepted vote locks
    add("voto_morto",   S_VOTO|S_CONF,  0, 5'b11110, 3, 2, 5'b00001, 0);
    add("voto2",        S_VOTO|S_CONF,  2, 5'b11110, 3, 2, 5'b11001, 0);
    add("voto_lock",    S_VOTO|S_CONF,  4, 5'b11110, 3, 2, 5'b11001, 0);
    // Night 2: angel protects the wolf's target
    add("zera2",        S_ZERA,         0, 5'b11110, 0, 0, 5'b11001, 0);
    add("n2_jog1",      S_INCJ,         0, 5'b11110, 1, 0, 5'b11001, 0);
    add("n2_jog2",      S_INCJ,         0, 5'b11110, 2, 1, 5'b11001, 0);
    add("n2_lobo1",     S_PROC|S_CONF,  1, 5'b11110, 2, 1, 5'b11001, 0);
    add("n2_jog3",      S_INCJ,         0, 5'b11110, 3, 2, 5'b11001, 0);
    add("n2_anjo1",     S_PROC|S_CONF,  1, 5'b11110, 3, 2, 5'b11001, 0);
    add("protegido",    S_AVAL,         0, 5'b11110, 3, 2, 5'b00000, 0);
    add("morra_sem_voto", S_MORRA,      0, 5'b11110, 3, 2, 5'b00000, 0);
    // Day 2: wrong vote for 4, lynched
    add("voto4",        S_VOTO|S_CONF,  4, 5'b11110, 3, 2, 5'b10000, 0);
    add("morra4",       S_MORRA,        0, 5'b01110, 3, 2, 5'b10000, 0);
    // Night 3: stale angel target cleared by zera_CJ, wolf kills 1 -> wolf wins
    add("zera3",        S_ZERA,         0, 5'b01110, 0, 0, 5'b10000, 0);
    add("n3_jog1",      S_INCJ,         0, 5'b01110, 1, 0, 5'b10000, 0);
    add("n3_jog2",      S_INCJ,         0, 5'b01110, 2, 1, 5'b10000, 0);
    add("n3_lobo1",     S_PROC|S_CONF,  1, 5'b01110, 2, 1, 5'b10000, 0);
    add("kill1_ganhou", S_AVAL,         0, 5'b01100, 2, 1, 5'b00011, 1);
    // Player counter saturates at N-1
    add("cnt_zera",     S_ZERA,         0, 5'b01100, 0, 0, 5'b00011, 1);
    add("cnt1",         S_INCJ,         0, 5'b01100, 1, 0, 5'b00011, 1);
    add("cnt2",         S_INCJ,         0, 5'b01100, 2, 1, 5'b00011, 1);
    add("cnt3",         S_INCJ,         0, 5'b01100, 3, 2, 5'b00011, 1);
    add("cnt4_fim",     S_INCJ,         0, 5'b01100, 4, 0, 5'b00111, 1);
    add("cnt_sat",      S_INCJ,         0, 5'b01100, 4, 0, 5'b00111, 1);
    run_tab();

    // Asynchronous reset mid-night: must act without a clock edge
    drive(S_PROC, 3'd1);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset", 5'b11111, 3'd0, 2'd1, 5'b00000, 3'd0);
    drive('0, '0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // rst_global priority, and anjo wrap when lobo = N-1
    add("r_voto3",      S_VOTO|S_CONF,  3, 5'b11111, 0, 1, 5'b10000, 0);
    add("r_morra3",     S_MORRA,        0, 5'b10111, 0, 1, 5'b10000, 0);
    add("r_incs",       S_INCS,         0, 5'b10111, 0, 1, 5'b10000, 0);
    add("r_jog1",       S_INCJ,         0, 5'b10111, 1, 2, 5'b10000, 0);
    add("rst_global",   S_RST|S_INCS|S_INCJ|S_ESEED|S_VOTO|S_CONF, 0,
                                           5'b11111, 0, 1, 5'b00000, 0);
    add("seed_limpo",   S_ESEED,        0, 5'b11111, 0, 1, 5'b00000, 0);
    for (int i = 0; i < 4; i++) add("incs4", S_INCS, 0, 5'b11111, 0, 1, 5'b00000, 0);
    add("lobo4_anjo0",  S_ESEED,        0, 5'b11111, 0, 2, 5'b00000, 0);
    add("w_jog1",       S_INCJ,         0, 5'b11111, 1, 0, 5'b00000, 0);
    add("w_jog2",       S_INCJ,         0, 5'b11111, 2, 0, 5'b00000, 0);
    add("w_jog3",       S_INCJ,         0, 5'b11111, 3, 0, 5'b00000, 0);
    add("w_jog4_lobo",  S_INCJ,         0, 5'b11111, 4, 1, 5'b00100, 0);
    add("zera_prio",    S_ZERA|S_INCJ,  0, 5'b11111, 0, 2, 5'b00000, 0);
    run_tab();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
